ccff_chain_loader: RTL and testbench

//  Configuration-chain controller for switch-block tiles. Accepts bitstream words on a

---
 rtl/ccff_chain_loader.sv | 141 ++++++++++++++
 tb/tb_ccff_chain_loader.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: serialises bitstream words into ccff_head and
// returns the displaced configuration from ccff_tail as readback words.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 36,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] wdata,
  input  logic              wvalid,
  output logic              wready,
  output logic              ccff_head,
  output logic              ccff_en,
  input  logic              ccff_tail,
  output logic [WORD_W-1:0] rdata,
  output logic              rvalid,
  input  logic              rready,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int BW = $clog2(WORD_W + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    FLUSH,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [WORD_W-1:0] sreg;
  logic [WORD_W-1:0] rbuf;
  logic [WORD_W-1:0] rbuf_nxt;
  logic [CW-1:0]     remaining;
  logic [BW-1:0]     nbits;
  logic [BW-1:0]     rcnt;
  logic              accept;
  logic              last_bit;
  logic              word_end;
  logic              rb_fire;
  logic              go;

  always_ff @(posedge prog_clk) begin
    if (!pReset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wready    = (state == LOAD);
    accept    = wready & wvalid;
    ccff_en   = (state == SHIFT) & ~(rvalid & ~rready);
    ccff_head = ccff_en & sreg[0];
    busy      = (state == LOAD) | (state == SHIFT) |
                (state == FLUSH);
    done      = (state == DONE);
    last_bit  = (remaining == CW'(1));
    word_end  = (nbits == BW'(1));
    rb_fire   = ccff_en &
                (last_bit | (rcnt == BW'(WORD_W - 1)));
    go        = start & ((state == IDLE) | (state == DONE));
    rbuf_nxt  = rbuf | (WORD_W'(ccff_tail) << rcnt);
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:  if (start) state_nxt = LOAD;
        LOAD:  if (accept) state_nxt = SHIFT;
        SHIFT: begin
          if (ccff_en) begin
            if (last_bit)      state_nxt = FLUSH;
            else if (word_end) state_nxt = LOAD;
          end
        end
        FLUSH: if (!rvalid || rready) state_nxt = DONE;
        DONE:  if (start) state_nxt = LOAD;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge prog_clk) begin
    if (!pReset) begin
      sreg      <= '0;
      rbuf      <= '0;
      remaining <= '0;
      nbits     <= '0;
      rcnt      <= '0;
      rdata     <= '0;
      rvalid    <= 1'b0;
    end else if (abort) begin
      sreg      <= '0;
      rbuf      <= '0;
      remaining <= '0;
      nbits     <= '0;
      rcnt      <= '0;
      rdata     <= '0;
      rvalid    <= 1'b0;
    end else begin
      if (go) begin
        remaining <= CW'(CHAIN_LEN);
        rbuf      <= '0;
        rcnt      <= '0;
      end
      // the last word of a load only carries the bits still owed
      if (accept) begin
        sreg  <= wdata;
        nbits <= (int'(remaining) < WORD_W) ?
                 BW'(remaining) : BW'(WORD_W);
      end
      if (ccff_en) begin
        sreg      <= sreg >> 1;
        remaining <= remaining - CW'(1);
        nbits     <= nbits - BW'(1);
        if (rb_fire) begin
          rdata <= rbuf_nxt;
          rbuf  <= '0;
          rcnt  <= '0;
        end else begin
          rbuf <= rbuf_nxt;
          rcnt <= rcnt + BW'(1);
        end
      end
      if (rb_fire) begin
        rvalid <= 1'b1;
      end else if (rready) begin
        rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: tile chain model, bit-queue reference,
// scoreboard for head stream and readback words.
module tb_ccff_chain_loader;

  localparam int CL = 36;
  localparam int WW = 8;
  localparam int NW = (CL + WW - 1) / WW;

  logic          clk = 1'b0;
  logic          pReset;
  logic          start;
  logic          abort;
  logic [WW-1:0] wdata;
  logic          wvalid;
  logic          wready;
  logic          ccff_head;
  logic          ccff_en;
  logic          ccff_tail;
  logic [WW-1:0] rdata;
  logic          rvalid;
  logic          rready;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
    .prog_clk (clk),
    .pReset   (pReset),
    .start    (start),
    .abort    (abort),
    .wdata    (wdata),
    .wvalid   (wvalid),
    .wready   (wready),
    .ccff_head(ccff_head),
    .ccff_en  (ccff_en),
    .ccff_tail(ccff_tail),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .rready   (rready),
    .busy     (busy),
    .done     (done)
  );

  // tile chain: head enters bit 0, tail leaves bit CL-1
  logic [CL-1:0] tchain;
  logic [CL-1:0] tinit;
  logic          tload = 1'b1;
  assign ccff_tail = tchain[CL-1];

  always @(posedge clk) begin
    if (tload) tchain <= tinit;
    else if (ccff_en) tchain <= {tchain[CL-2:0], ccff_head};
  end

  int n_cmp = 0;
  int n_bad = 0;
  int rx_cnt = 0;
  int shifts_done = 0;
  bit stop_feed = 0;

  bit            head_q[$];
  logic [WW-1:0] exp_rb[$];
  bit            ref_chain[$];
  logic [WW-1:0] words[NW];
  bit            mon_b;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) if (ccff_en === 1'b1) shifts_done <= shifts_done + 1;

  // monitor: head stream and readback words against the scoreboard
  always @(negedge clk) begin
    if (ccff_en === 1'b1) begin
      if (head_q.size() == 0) begin
        chk("head_unexpected", 1, 0);
      end else begin
        mon_b = head_q.pop_front();
        chk("ccff_head", ccff_head, mon_b);
        void'(ref_chain.pop_front());
        ref_chain.push_back(mon_b);
      end
    end else if (ccff_en === 1'b0) begin
      chk("head_idle", ccff_head, 0);
    end
    if (rvalid === 1'b1 && rready === 1'b1) begin
      rx_cnt++;
      if (exp_rb.size() == 0) chk("rdata_unexpected", 1, 0);
      else chk("rdata", rdata, exp_rb.pop_front());
    end
  end

  task automatic run_load(input int gap, input bit chk_lat,
                          input int stop_at, input bit use_rst,
                          input bit pulse_start, input int rmode);
    logic [WW-1:0] v;
    logic [CL-1:0] exp_chain;
    int rx0, sh0, c;
    for (int i = 0; i < CL; i++) begin
      head_q.push_back(words[i / WW][i % WW]);
      exp_chain[CL-1-i] = words[i / WW][i % WW];
    end
    for (int w = 0; w < NW; w++) begin
      v = '0;
      for (int b = 0; b < WW; b++)
        if (w * WW + b < CL) v[b] = ref_chain[w * WW + b];
      exp_rb.push_back(v);
    end
    stop_feed = 0;
    rx0 = rx_cnt;
    sh0 = shifts_done;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    fork
      begin : feeder
        for (int w = 0; w < NW; w++) begin
          int k;
          int g;
          k = 0;
          while (!wready && !stop_feed && k < 300) begin
            @(posedge clk); #1; k++;
          end
          if (stop_feed) break;
          if (!wready) begin
            chk("wready_timeout", 0, 1);
            break;
          end
          g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
          for (int j = 0; j < g; j++) begin
            chk("gap_wready", wready, 1);
            chk("gap_en", ccff_en, 0);
            @(posedge clk); #1;
          end
          wdata = words[w];
          wvalid = 1'b1;
          @(posedge clk); #1;
          wvalid = 1'b0;
          wdata = WW'($urandom);
        end
      end
      begin : latency
        if (chk_lat) begin
          int n;
          n = 0;
          while (!done && n < 200) begin
            @(posedge clk); #1; n++;
          end
          chk("done_latency", n, NW + CL + 1);
        end
      end
      begin : stopper
        if (stop_at > 0) begin
          int k;
          k = 0;
          while (shifts_done - sh0 < stop_at && k < 500) begin
            @(posedge clk); #1; k++;
          end
          chk("stop_reached", shifts_done - sh0, stop_at);
          if (use_rst) pReset = 1'b0;
          else abort = 1'b1;
          stop_feed = 1;
          @(posedge clk); #1;
          if (use_rst)
            chk("reset_outputs",
                {wready, ccff_head, ccff_en, rdata, rvalid, busy, done}, 0);
          else
            chk("abort_outputs", {wready, rvalid, busy, done}, 0);
          abort = 1'b0;
          pReset = 1'b1;
          chk("words_before_stop", rx_cnt - rx0, stop_at / WW);
        end
      end
      begin : pulser
        if (pulse_start) begin
          repeat (20) @(posedge clk);
          #1;
          chk("busy_at_pulse", busy, 1);
          start = 1'b1;
          @(posedge clk); #1;
          start = 1'b0;
        end
      end
      begin : rdy
        if (rmode == 1) begin
          logic [WW-1:0] held;
          int k;
          k = 0;
          while (!rvalid && k < 100) begin
            @(posedge clk); #1; k++;
          end
          chk("first_rvalid", rvalid, 1);
          rready = 1'b0;
          held = rdata;
          repeat (6) begin
            @(posedge clk); #1;
            chk("stall_en", ccff_en, 0);
            chk("stall_rdata", rdata, held);
            chk("stall_rvalid", rvalid, 1);
          end
          rready = 1'b1;
        end else if (rmode == 2) begin
          int k;
          k = 0;
          while (!done && k < 1000) begin
            rready = 1'($urandom_range(0, 1));
            @(posedge clk); #1; k++;
          end
          rready = 1'b1;
        end
      end
    join
    if (stop_at > 0) begin
      head_q.delete();
      exp_rb.delete();
    end else begin
      c = 0;
      while (!done && c < 2000) begin
        @(posedge clk); #1; c++;
      end
      chk("done", done, 1);
      chk("busy_done", busy, 0);
      chk("rb_count", rx_cnt - rx0, NW);
      chk("rb_left", exp_rb.size(), 0);
      chk("head_left", head_q.size(), 0);
      chk("chain", tchain, exp_chain);
    end
  endtask

  initial begin
    pReset = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    wvalid = 1'b0;
    wdata = '0;
    rready = 1'b1;
    tinit = {$urandom, $urandom};
    for (int i = 0; i < CL; i++) ref_chain.push_back(tinit[CL-1-i]);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state",
        {wready, ccff_head, ccff_en, rdata, rvalid, busy, done}, 0);
    tload = 1'b0;
    pReset = 1'b1;
    @(posedge clk); #1;

    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF;
    words[3] = 8'h00; words[4] = 8'h09;
    run_load(0, 1, 0, 0, 0, 0);

    for (int w = 0; w < NW; w++) words[w] = '0;
    chk("reload_expect0", exp_rb.size(), 0);
    run_load(0, 1, 0, 0, 0, 0);

    for (int w = 0; w < NW; w++) words[w] = WW'($urandom);
    run_load(0, 0, 0, 0, 0, 1);

    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF;
    words[3] = 8'h00; words[4] = 8'h09;
    run_load(3, 0, 0, 0, 0, 0);

    for (int w = 0; w < NW; w++) words[w] = WW'($urandom);
    run_load(0, 0, 17, 0, 0, 0);
    for (int w = 0; w < NW; w++) words[w] = WW'($urandom);
    run_load(0, 1, 0, 0, 0, 0);

    for (int w = 0; w < NW; w++) words[w] = WW'($urandom);
    run_load(0, 0, 10, 1, 0, 0);
    for (int w = 0; w < NW; w++) words[w] = WW'($urandom);
    run_load(0, 1, 0, 0, 1, 0);

    for (int t = 0; t < 4; t++) begin
      for (int w = 0; w < NW; w++) words[w] = WW'($urandom);
      run_load(-1, 0, 0, 0, 0, 2);
    end

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
